// File: rtl/apu_mixer_pipe.sv
// Five-channel NES APU output mixer: masked capture, non-linear pulse/TND tables,
// per-bus gain with saturation and a leaky DC blocker, one sample per clock.
module apu_mixer_pipe #(
  parameter int OUT_WIDTH  = 16,
  parameter int GAIN_WIDTH = 8,
  parameter int DC_SHIFT   = 10
) (
  input  logic                  iClk,
  input  logic                  iRst_n,
  input  logic                  iSampleStb,
  input  logic [3:0]            iRectangle1,
  input  logic [3:0]            iRectangle2,
  input  logic [3:0]            iTriangle,
  input  logic [3:0]            iNoise,
  input  logic [6:0]            iDMC,
  input  logic [4:0]            iMute,
  input  logic [GAIN_WIDTH-1:0] iGainSq,
  input  logic [GAIN_WIDTH-1:0] iGainTnd,
  input  logic                  iClipClr,
  output logic [OUT_WIDTH-1:0]  oData,
  output logic [OUT_WIDTH-1:0]  oDataAc,
  output logic                  oValid,
  output logic                  oClip
);

  localparam int SQ_ENTRIES = 31;
  localparam int TQ_ENTRIES = 203;
  localparam int P_WIDTH    = 10 + GAIN_WIDTH;
  localparam int ACC_WIDTH  = OUT_WIDTH + DC_SHIFT + 2;

  localparam logic [P_WIDTH-1:0]          SAT_MAX = P_WIDTH'({OUT_WIDTH{1'b1}});
  localparam logic signed [ACC_WIDTH-1:0] AC_MAX  = ACC_WIDTH'((1 <<< (OUT_WIDTH - 1)) - 1);
  localparam logic signed [ACC_WIDTH-1:0] AC_MIN  = -AC_MAX - ACC_WIDTH'(1);

  // Exact integer form of 512*95.52/(8128/i+100) = 4890624*i / (812800 + 10000*i).
  function automatic logic [8:0] sq_entry(input int unsigned idx);
    longint unsigned i;
    longint unsigned q;
    i = 64'(idx);
    q = (64'd4890624 * i) / (64'd812800 + 64'd10000 * i);
    return 9'(q);
  endfunction

  // 512*163.67/(24329/i+100) = 8379904*i / (2432900 + 10000*i); the curve
  // tops out at 379 so the last index (raw 380.1) is held at the table ceiling.
  function automatic logic [8:0] tq_entry(input int unsigned idx);
    longint unsigned i;
    longint unsigned q;
    i = 64'(idx);
    q = (64'd8379904 * i) / (64'd2432900 + 64'd10000 * i);
    if (q > 64'd379) q = 64'd379;
    return 9'(q);
  endfunction

  // NOTE: ROM contents are elaboration constants; only the pipeline flops need reset.
  logic [8:0] sq_rom [SQ_ENTRIES];
  logic [8:0] tq_rom [TQ_ENTRIES];

  for (genvar g = 0; g < SQ_ENTRIES; g++) begin : g_sq_rom
    localparam logic [8:0] ENTRY = sq_entry(g);
    assign sq_rom[g] = ENTRY;
  end

  for (genvar g = 0; g < TQ_ENTRIES; g++) begin : g_tq_rom
    localparam logic [8:0] ENTRY = tq_entry(g);
    assign tq_rom[g] = ENTRY;
  end

  // S0: masked channel levels and gains
  logic                  s0_valid_q;
  logic [3:0]            s0_rect1_q, s0_rect2_q, s0_tri_q, s0_noise_q;
  logic [6:0]            s0_dmc_q;
  logic [GAIN_WIDTH-1:0] s0_gain_sq_q, s0_gain_tnd_q;

  // NOTE: every flop uses <= so each stage samples its predecessor's old value.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      s0_valid_q    <= 1'b0;
      s0_rect1_q    <= '0;
      s0_rect2_q    <= '0;
      s0_tri_q      <= '0;
      s0_noise_q    <= '0;
      s0_dmc_q      <= '0;
      s0_gain_sq_q  <= '0;
      s0_gain_tnd_q <= '0;
    end else begin
      s0_valid_q <= iSampleStb;
      if (iSampleStb) begin
        s0_rect1_q    <= iMute[0] ? 4'd0 : iRectangle1;
        s0_rect2_q    <= iMute[1] ? 4'd0 : iRectangle2;
        s0_tri_q      <= iMute[2] ? 4'd0 : iTriangle;
        s0_noise_q    <= iMute[3] ? 4'd0 : iNoise;
        s0_dmc_q      <= iMute[4] ? 7'd0 : iDMC;
        s0_gain_sq_q  <= iGainSq;
        s0_gain_tnd_q <= iGainTnd;
      end
    end
  end

  // S1: table indices
  logic [4:0]            rect_d, s1_rect_q;
  logic [7:0]            tnd_d, s1_tnd_q;
  logic                  s1_valid_q;
  logic [GAIN_WIDTH-1:0] s1_gain_sq_q, s1_gain_tnd_q;

  always_comb begin
    rect_d = 5'(s0_rect1_q) + 5'(s0_rect2_q);
    tnd_d  = 8'(s0_tri_q) + {3'b000, s0_tri_q, 1'b0} + {3'b000, s0_noise_q, 1'b0}
           + 8'(s0_dmc_q);
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      s1_valid_q    <= 1'b0;
      s1_rect_q     <= '0;
      s1_tnd_q      <= '0;
      s1_gain_sq_q  <= '0;
      s1_gain_tnd_q <= '0;
    end else begin
      s1_valid_q <= s0_valid_q;
      if (s0_valid_q) begin
        s1_rect_q     <= rect_d;
        s1_tnd_q      <= tnd_d;
        s1_gain_sq_q  <= s0_gain_sq_q;
        s1_gain_tnd_q <= s0_gain_tnd_q;
      end
    end
  end

  // S2: registered table read
  logic                  s2_valid_q;
  logic [8:0]            s2_sq_q, s2_tq_q;
  logic [GAIN_WIDTH-1:0] s2_gain_sq_q, s2_gain_tnd_q;

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      s2_valid_q    <= 1'b0;
      s2_sq_q       <= '0;
      s2_tq_q       <= '0;
      s2_gain_sq_q  <= '0;
      s2_gain_tnd_q <= '0;
    end else begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_sq_q       <= sq_rom[s1_rect_q];
        s2_tq_q       <= tq_rom[s1_tnd_q];
        s2_gain_sq_q  <= s1_gain_sq_q;
        s2_gain_tnd_q <= s1_gain_tnd_q;
      end
    end
  end

  // S3: gain, saturation, clip flag and DC blocker share one register stage
  logic [P_WIDTH-1:0]          mix_p;
  logic                        mix_over;
  logic [OUT_WIDTH-1:0]        mix_sat;
  logic signed [ACC_WIDTH-1:0] dc_s, diff_s;
  logic [OUT_WIDTH-1:0]        ac_sat;

  logic [OUT_WIDTH-1:0]        data_d, data_q;
  logic [OUT_WIDTH-1:0]        ac_d, ac_q;
  logic signed [ACC_WIDTH-1:0] acc_d, acc_q;
  logic                        valid_d, valid_q;
  logic                        clip_d, clip_q;

  always_comb begin
    mix_p    = P_WIDTH'(s2_sq_q) * P_WIDTH'(s2_gain_sq_q)
             + P_WIDTH'(s2_tq_q) * P_WIDTH'(s2_gain_tnd_q);
    mix_over = (mix_p > SAT_MAX);
    mix_sat  = mix_over ? {OUT_WIDTH{1'b1}} : mix_p[OUT_WIDTH-1:0];

    dc_s   = acc_q >>> DC_SHIFT;
    diff_s = $signed(ACC_WIDTH'(mix_sat)) - dc_s;
    if (diff_s > AC_MAX)      ac_sat = OUT_WIDTH'(AC_MAX);
    else if (diff_s < AC_MIN) ac_sat = OUT_WIDTH'(AC_MIN);
    else                      ac_sat = diff_s[OUT_WIDTH-1:0];
  end

  // NOTE: every next-state variable gets its hold value first, so no path infers a latch.
  always_comb begin
    data_d  = data_q;
    ac_d    = ac_q;
    acc_d   = acc_q;
    valid_d = s2_valid_q;
    clip_d  = clip_q;
    if (iClipClr) clip_d = 1'b0;
    if (s2_valid_q) begin
      data_d = mix_sat;
      ac_d   = ac_sat;
      acc_d  = acc_q + diff_s;
      if (mix_over) clip_d = 1'b1;
    end
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      data_q  <= '0;
      ac_q    <= '0;
      acc_q   <= '0;
      valid_q <= 1'b0;
      clip_q  <= 1'b0;
    end else begin
      data_q  <= data_d;
      ac_q    <= ac_d;
      acc_q   <= acc_d;
      valid_q <= valid_d;
      clip_q  <= clip_d;
    end
  end

  assign oData   = data_q;
  assign oDataAc = ac_q;
  assign oValid  = valid_q;
  assign oClip   = clip_q;

endmodule

// File: tb/tb_apu_mixer_pipe.sv
// Self-checking bench for apu_mixer_pipe: vector table plus hand sequences,
// expected samples queued at the strobe and compared when oValid fires.
module tb_apu_mixer_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stb;
  logic [3:0]  r1, r2, tri_lv, noise_lv;
  logic [6:0]  dmc_lv;
  logic [4:0]  mute;
  logic [7:0]  gsq, gtnd;
  logic        clr;
  logic [15:0] o_data, o_ac, o_data4, o_ac4;
  logic        o_valid, o_clip, o_valid4, o_clip4;

  always #5 clk = ~clk;

  apu_mixer_pipe dut (
    .iClk(clk), .iRst_n(rst_n), .iSampleStb(stb),
    .iRectangle1(r1), .iRectangle2(r2), .iTriangle(tri_lv), .iNoise(noise_lv),
    .iDMC(dmc_lv), .iMute(mute), .iGainSq(gsq), .iGainTnd(gtnd), .iClipClr(clr),
    .oData(o_data), .oDataAc(o_ac), .oValid(o_valid), .oClip(o_clip)
  );

  apu_mixer_pipe #(.DC_SHIFT(4)) dut4 (
    .iClk(clk), .iRst_n(rst_n), .iSampleStb(stb),
    .iRectangle1(r1), .iRectangle2(r2), .iTriangle(tri_lv), .iNoise(noise_lv),
    .iDMC(dmc_lv), .iMute(mute), .iGainSq(gsq), .iGainTnd(gtnd), .iClipClr(clr),
    .oData(o_data4), .oDataAc(o_ac4), .oValid(o_valid4), .oClip(o_clip4)
  );

  typedef struct {
    string name;
    int    data;
    int    ac;
    bit    clip;
  } exp_t;

  typedef struct {
    string      name;
    logic [3:0] a, b, t, n;
    logic [6:0] d;
    logic [4:0] m;
    logic [7:0] gs, gt;
    int         exp;
  } vec_t;

  int     tests_run    = 0;
  int     tests_failed = 0;
  exp_t   sb[$];
  longint acc_m  = 0;
  bit     clip_m = 1'b0;
  int     valid_seen = 0;
  int     run_len = 0;
  int     max_run = 0;

  bit     dc4_track = 1'b0;
  int     dc4_cnt = 0;
  int     dc4_rise = 0;
  longint dc4_first = 0;
  longint dc4_prev = 0;

  task automatic check(input string name, input longint act, input longint exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int sq_ref(input int idx);
    real v;
    if (idx == 0) return 0;
    v = 512.0 * 95.52 / (8128.0 / idx + 100.0);
    return int'($floor(v + 1.0e-9));
  endfunction

  function automatic int tq_ref(input int idx);
    real v;
    int  q;
    if (idx == 0) return 0;
    v = 512.0 * 163.67 / (24329.0 / idx + 100.0);
    q = int'($floor(v + 1.0e-9));
    return (q > 379) ? 379 : q;
  endfunction

  function automatic int model_p(input int a, b, t, n, d, input logic [4:0] m, input int gs, gt);
    int ra, rb, tt, nn, dd;
    ra = m[0] ? 0 : a;
    rb = m[1] ? 0 : b;
    tt = m[2] ? 0 : t;
    nn = m[3] ? 0 : n;
    dd = m[4] ? 0 : d;
    return sq_ref(ra + rb) * gs + tq_ref(3 * tt + 2 * nn + dd) * gt;
  endfunction

  function automatic int sat16(input longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return int'(v);
  endfunction

  task automatic push(input string name, input int p, input int exp_data);
    exp_t   e;
    longint diff;
    if (p > 65535) clip_m = 1'b1;
    diff   = longint'(exp_data) - (acc_m >>> 10);
    acc_m  = acc_m + diff;
    e.name = name;
    e.data = exp_data;
    e.ac   = sat16(diff);
    e.clip = clip_m;
    sb.push_back(e);
  endtask

  task automatic strobe(input string name, input logic [3:0] a, b, t, n, input logic [6:0] d,
                        input logic [4:0] m, input logic [7:0] gs, gt, input int exp_data);
    r1 = a; r2 = b; tri_lv = t; noise_lv = n; dmc_lv = d; mute = m; gsq = gs; gtnd = gt;
    stb = 1'b1;
    push(name, model_p(int'(a), int'(b), int'(t), int'(n), int'(d), m, int'(gs), int'(gt)),
         exp_data);
    @(posedge clk); #1;
    stb = 1'b0;
  endtask

  task automatic drain();
    repeat (7) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && o_valid) begin
      valid_seen++;
      run_len++;
      if (run_len > max_run) max_run = run_len;
      if (sb.size() == 0) begin
        check("unexpected_valid", longint'(o_valid), 0);
      end else begin
        e = sb.pop_front();
        check({e.name, "_data"}, longint'(o_data), e.data);
        check({e.name, "_ac"}, longint'($signed(o_ac)), e.ac);
        check({e.name, "_clip"}, longint'(o_clip), longint'(e.clip));
      end
    end else begin
      run_len = 0;
    end
  end

  always @(negedge clk) begin : monitor_dc4
    if (rst_n && o_valid4 && dc4_track) begin
      if (dc4_cnt == 0) dc4_first = longint'($signed(o_ac4));
      else if (longint'($signed(o_ac4)) > dc4_prev) dc4_rise++;
      dc4_prev = longint'($signed(o_ac4));
      dc4_cnt++;
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    vec_t vecs[8];
    int   seq_exp[6];
    int   lat;
    int   v0;

    vecs[0] = '{"mute_all",     4'd15, 4'd15, 4'd15, 4'd15, 7'd127, 5'h1f,      8'd255, 8'd255, 0};
    vecs[1] = '{"tnd_max",      4'd0,  4'd0,  4'd15, 4'd15, 7'd127, 5'h00,      8'd0,   8'd128, 48512};
    vecs[2] = '{"tnd_mute_dmc", 4'd0,  4'd0,  4'd15, 4'd15, 7'd127, 5'b10000,   8'd0,   8'd128, 25216};
    vecs[3] = '{"sq15",         4'd15, 4'd15, 4'd0,  4'd0,  7'd0,   5'b00010,   8'd128, 8'd0,   9728};
    vecs[4] = '{"tq45",         4'd0,  4'd0,  4'd0,  4'd0,  7'd45,  5'h00,      8'd0,   8'd200, 26000};
    vecs[5] = '{"full_128",     4'd15, 4'd15, 4'd15, 4'd15, 7'd127, 5'h00,      8'd128, 8'd128, 65280};
    vecs[6] = '{"all_max_255",  4'd15, 4'd15, 4'd15, 4'd15, 7'd127, 5'h00,      8'd255, 8'd255, 65535};
    vecs[7] = '{"after_clip",   4'd1,  4'd0,  4'd0,  4'd0,  7'd0,   5'h00,      8'd1,   8'd0,   5};
    seq_exp = '{0, 5, 11, 17, 22, 28};

    // Reset with every input at its maximum and no strobe
    rst_n = 1'b0; stb = 1'b0; clr = 1'b0;
    r1 = 4'd15; r2 = 4'd15; tri_lv = 4'd15; noise_lv = 4'd15; dmc_lv = 7'd127;
    mute = 5'h1f; gsq = 8'd255; gtnd = 8'd255;
    repeat (3) @(posedge clk);
    #1;
    check("rst_data", longint'(o_data), 0);
    check("rst_ac", longint'(o_ac), 0);
    check("rst_valid", longint'(o_valid), 0);
    check("rst_clip", longint'(o_clip), 0);
    rst_n = 1'b1;
    acc_m = 0; clip_m = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("no_valid_after_release", valid_seen, 0);

    // First sample: latency of exactly four edges
    r1 = 4'd15; r2 = 4'd15; tri_lv = 4'd0; noise_lv = 4'd0; dmc_lv = 7'd0;
    mute = 5'h00; gsq = 8'd128; gtnd = 8'd0;
    stb = 1'b1;
    push("first", model_p(15, 15, 0, 0, 0, 5'h00, 128, 0), 16768);
    lat = -1;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1;
      stb = 1'b0;
      @(negedge clk);
      if (o_valid && lat < 0) lat = i;
    end
    check("latency", lat, 4);
    #1;

    for (int i = 0; i < 8; i++)
      strobe(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].t, vecs[i].n, vecs[i].d,
             vecs[i].m, vecs[i].gs, vecs[i].gt, vecs[i].exp);
    drain();
    check("clip_sticky", longint'(o_clip), 1);

    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    check("clip_cleared", longint'(o_clip), 0);
    clip_m = 1'b0;

    // Clear lands on the same edge as a clipping sample: set wins
    strobe("clip_vs_clr", 4'd15, 4'd15, 4'd15, 4'd15, 7'd127, 5'h00, 8'd255, 8'd255, 65535);
    repeat (2) @(posedge clk);
    #1;
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    check("clip_set_priority", longint'(o_clip), 1);
    drain();
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    check("clip_cleared_again", longint'(o_clip), 0);
    clip_m = 1'b0;

    // Six back-to-back strobes
    v0 = valid_seen;
    max_run = 0;
    for (int i = 0; i < 6; i++)
      strobe($sformatf("seq%0d", i), 4'(i), 4'd0, 4'd0, 4'd0, 7'd0, 5'h00, 8'd1, 8'd0,
             seq_exp[i]);
    drain();
    check("seq_count", valid_seen - v0, 6);
    check("seq_back_to_back", max_run, 6);

    // Reset two cycles after a strobe discards the sample
    v0 = valid_seen;
    r1 = 4'd15; r2 = 4'd15; gsq = 8'd128; gtnd = 8'd0; mute = 5'h00;
    stb = 1'b1;
    @(posedge clk); #1;
    stb = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    acc_m = 0; clip_m = 1'b0;
    check("rst_mid_data", longint'(o_data), 0);
    repeat (8) @(posedge clk);
    #1;
    check("rst_mid_no_valid", valid_seen - v0, 0);

    // Constant mix into both blockers; the DC_SHIFT=4 instance must settle
    dc4_track = 1'b1;
    for (int i = 0; i < 512; i++)
      strobe("const", 4'd15, 4'd15, 4'd0, 4'd0, 7'd0, 5'h00, 8'd128, 8'd0, 16768);
    drain();
    dc4_track = 1'b0;
    check("dc4_count", dc4_cnt, 512);
    check("dc4_first", dc4_first, 16768);
    check("dc4_monotonic_rises", dc4_rise, 0);
    check("dc4_settled", longint'(dc4_prev >= -1 && dc4_prev <= 1), 1);
    check("dc4_data", longint'(o_data4), 16768);
    check("dc4_clip", longint'(o_clip4), 0);

    check("scoreboard_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/apu_mixer_pipe.md
Name: apu_mixer_pipe

Overview:
Five-channel NES APU output mixer with a registered pipeline. It captures pulse 1, pulse 2, triangle, noise and DMC levels on a sample strobe. It applies the non-linear pulse and TND mixing curves through internal tables, then per-bus gain with saturation and an optional-use DC-blocked signed output. It sits between the APU channel units and the audio DAC/I2S serializer. It adds the DMC channel, mute, gain, clipping detection and throughput of one sample per clock.

Parameters:
OUT_WIDTH, 16, width of oData and oDataAc.
GAIN_WIDTH, 8, width of iGainSq and iGainTnd (unsigned).
DC_SHIFT, 10, DC-blocker leak shift; cutoff is about Fs/(2π·2^DC_SHIFT).

Ports:
iClk  in  1  system clock
iRst_n  in  1  asynchronous active-low reset
iSampleStb  in  1  one-cycle strobe: capture channel inputs this cycle
iRectangle1  in  4  pulse 1 level
iRectangle2  in  4  pulse 2 level
iTriangle  in  4  triangle level
iNoise  in  4  noise level
iDMC  in  7  DMC level
iMute  in  5  per-channel mute {DMC,noise,tri,rect2,rect1}; 1 forces that level to 0
iGainSq  in  GAIN_WIDTH  pulse-bus gain
iGainTnd  in  GAIN_WIDTH  TND-bus gain
iClipClr  in  1  clears oClip
oData  out  OUT_WIDTH  unsigned saturated mix
oDataAc  out  OUT_WIDTH  signed two's-complement DC-removed mix
oValid  out  1  one-cycle pulse: oData/oDataAc updated
oClip  out  1  sticky saturation flag

Behaviour:
- Reset: the asynchronous reset clears all pipeline registers, valid bits and the DC accumulator. oData=0, oDataAc=0, oValid=0, oClip=0.
- Pipeline: 4 stages, each with a valid bit. It accepts iSampleStb every cycle (no backpressure). oValid asserts exactly 4 cycles after the iSampleStb edge. Gains are sampled with the channel levels at S0.
- S0 capture: on iSampleStb, register masked levels and both gains.
- S1 index:
  - rect = r1+r2 (5 bits, 0..30).
  - tnd = 3·t + 2·n + d (8 bits, 0..202).
- S2 lookup: registered table read.
  - sq = floor(512·95.52/(8128/rect+100)), giving 0..131 (9 bits).
  - tq = floor(512·163.67/(24329/tnd+100)), giving 0..379 (9 bits).
  - Entries for index 0 are 0.
  - Anchor values: sq[30]=131, sq[15]=76, tq[202]=379, tq[45]=130.
- S3 gain:
  - P = sq·iGainSq + tq·iGainTnd (unsigned, 10+GAIN_WIDTH bits).
  - oData = min(P, 2^OUT_WIDTH−1).
  - If P exceeds that limit, set oClip. oClip stays set until iClipClr; set has priority when both occur in the same cycle.
- DC blocker, updated in the same register stage as oData on each valid sample:
  - x = saturated mix; dc = acc >>> DC_SHIFT.
  - oDataAc = sat_signed(x − dc).
  - acc ← acc + (x − dc). acc is signed, OUT_WIDTH+DC_SHIFT+2 bits.
  - Constant input converges to oDataAc = 0.
  - oDataAc saturates to [−2^(OUT_WIDTH−1), 2^(OUT_WIDTH−1)−1].
- No valid sample: all outputs hold their value; oValid=0.
- Reset mid-pipeline: in-flight samples are discarded; no oValid follows reset release until a new strobe.
- Out-of-range indices are impossible by construction; tables need no entries beyond 30/202.

Test Plan:
- Reset with all inputs at max, no strobe → oData=0, oDataAc=0, oValid=0, oClip=0. No oValid after release until the first strobe.
- r1=r2=15, others 0, iGainSq=128, iGainTnd=0, one strobe at cycle N → oValid at N+4, oData=16768, oDataAc=16768 (first sample), oClip=0.
- t=15, n=15, d=127, pulses 0, iGainTnd=128 → oData=48512. Same inputs with iMute=5'b10000 → index 75, oData=197·128=25216.
- All channels max, both gains 255 → oData=65535, oClip=1. oClip held across later non-clipping samples; iClipClr pulse → oClip=0.
- Strobe on 6 consecutive cycles, r1 = 0,1,…,5 with r2=0 and iGainSq=1 → six back-to-back oValid pulses, oData = 0,5,11,17,22,28 in order.
- DC_SHIFT=4, constant mix 16768 strobed 512 times → oDataAc decays monotonically from 16768 to |oDataAc|≤1.
- Assert iRst_n low 2 cycles after a strobe → no oValid for that sample.
